// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port DMEM between the CPU (port 0) and a debug/loader port (port 1).
// Define ARB_ADDR_CHECK_EN to suppress and flag accesses outside the DMEM window (err_o); otherwise addresses wrap.
module dmem_port_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int          AW        = 11,
    parameter int          MAX_WAIT  = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req0_i,
    input  logic          we0_i,
    input  logic [31:0]   addr0_i,
    input  logic [31:0]   wdata0_i,
    output logic          gnt0_o,
    output logic          rvalid0_o,
    output logic [31:0]   rdata0_o,
    input  logic          req1_i,
    input  logic          we1_i,
    input  logic [31:0]   addr1_i,
    input  logic [31:0]   wdata1_i,
    output logic          gnt1_o,
    output logic          rvalid1_o,
    output logic [31:0]   rdata1_o,
    output logic          err_o,
    output logic          dm_ena_o,
    output logic          dm_we_o,
    output logic [AW-1:0] dm_addr_o,
    output logic [31:0]   dm_wdata_o,
    input  logic [31:0]   dm_rdata_i
);
    typedef enum logic [1:0] {IDLE, RD0, RD1} state_e;
    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] rdata0_q, rdata1_q;
    logic        err_q;
    logic        force1, gnt, we, in_range;
    logic [31:0] off;
    logic        unused_ok;
    always_comb begin
        force1    = req1_i && (wait_q == 4'(MAX_WAIT));
        // Grants are masked while in reset so nothing reaches DMEM on that edge.
        gnt0_o    = rst_ni && req0_i && !force1;
        gnt1_o    = rst_ni && req1_i && (!req0_i || force1);
        gnt       = gnt0_o || gnt1_o;
        we        = gnt1_o ? we1_i : we0_i;
        off       = (gnt1_o ? addr1_i : addr0_i) - BASE_ADDR;
`ifdef ARB_ADDR_CHECK_EN
        in_range  = off[31:AW+2] == '0;
        unused_ok = ^off[1:0];
`else
        in_range  = 1'b1;
        unused_ok = ^{off[31:AW+2], off[1:0]};
`endif
        dm_ena_o   = gnt && in_range;
        dm_we_o    = dm_ena_o && we;
        dm_addr_o  = gnt ? off[AW+1:2] : '0;
        dm_wdata_o = !gnt ? '0 : gnt1_o ? wdata1_i : wdata0_i;
        wait_d     = (!req1_i || gnt1_o) ? 4'd0 : force1 ? wait_q : wait_q + 4'd1;
        state_d    = (gnt && !we) ? (gnt1_o ? RD1 : RD0) : IDLE;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= gnt && !in_range;
            if (gnt0_o && !we0_i) rdata0_q <= in_range ? dm_rdata_i : '0;
            if (gnt1_o && !we1_i) rdata1_q <= in_range ? dm_rdata_i : '0;
        end
    end
    assign rvalid0_o = state_q == RD0;
    assign rvalid1_o = state_q == RD1;
    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;
    assign err_o     = err_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: vector table plus read-return scoreboard for dmem_port_arbiter.
module tb_dmem_port_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err, dm_ena, dm_we;
    logic [31:0] rdata0, rdata1, dm_wdata, dm_rdata;
    logic [10:0] dm_addr;
    logic [31:0] mem [0:2047];
    logic [31:0] ref_mem [0:2047];
    logic [31:0] q0[$], q1[$];
    logic        exp_err;
    int          tests = 0, fails = 0;

    typedef struct {
        logic r0, w0; logic [31:0] a0, d0;
        logic r1, w1; logic [31:0] a1, d1;
        logic g0, g1, ena; logic [10:0] da;
    } vec_t;
    vec_t vecs[$];

    dmem_port_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
        .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
        .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1),
        .err_o(err), .dm_ena_o(dm_ena), .dm_we_o(dm_we), .dm_addr_o(dm_addr),
        .dm_wdata_o(dm_wdata), .dm_rdata_i(dm_rdata)
    );

    always #5 clk = ~clk;
    assign dm_rdata = mem[dm_addr];
    always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r0, w0, input logic [31:0] a0, d0,
                                input logic r1, w1, input logic [31:0] a1, d1,
                                input logic g0, g1, ena, input logic [10:0] da);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.ena = ena; v.da = da;
        return v;
    endfunction

    task automatic check_resp(input string nm);
        logic [31:0] d;
        chk({nm, " rvalid0"}, 32'(rvalid0), 32'(q0.size() != 0));
        if (q0.size() != 0) begin d = q0.pop_front(); chk({nm, " rdata0"}, rdata0, d); end
        chk({nm, " rvalid1"}, 32'(rvalid1), 32'(q1.size() != 0));
        if (q1.size() != 0) begin d = q1.pop_front(); chk({nm, " rdata1"}, rdata1, d); end
        chk({nm, " err"}, 32'(err), 32'(exp_err));
    endtask

    // Drive one vector, check the combinational grant/DMEM side, then the registered response.
    task automatic step(input vec_t v, input string nm);
        logic w;
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
        w = v.g1 ? v.w1 : v.w0;
        @(negedge clk);
        chk({nm, " gnt0"}, 32'(gnt0), 32'(v.g0));
        chk({nm, " gnt1"}, 32'(gnt1), 32'(v.g1));
        chk({nm, " dm_ena"}, 32'(dm_ena), 32'(v.ena));
        chk({nm, " dm_we"}, 32'(dm_we), 32'(v.ena && w));
        if (v.ena) chk({nm, " dm_addr"}, 32'(dm_addr), 32'(v.da));
        if (v.ena && w) chk({nm, " dm_wdata"}, dm_wdata, v.g1 ? v.d1 : v.d0);
        if (v.g0 && !v.w0) q0.push_back(v.ena ? ref_mem[v.da] : 32'h0);
        if (v.g1 && !v.w1) q1.push_back(v.ena ? ref_mem[v.da] : 32'h0);
        if (v.ena && w) ref_mem[v.da] = v.g1 ? v.d1 : v.d0;
        exp_err = (v.g0 || v.g1) && !v.ena;
        @(posedge clk); #1;
        check_resp(nm);
    endtask

    localparam logic [31:0] A4 = 32'h10010004, AC = 32'h1001000C;

    initial begin
        logic ob;
`ifdef ARB_ADDR_CHECK_EN
        ob = 1'b0;
`else
        ob = 1'b1;
`endif
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 32'h5A000000 | (i * 32'h00010003);
            ref_mem[i] = mem[i];
        end
        vecs.push_back(mk(1,1,32'h10010008,32'hDEADBEEF, 0,0,0,0,            1,0,1,11'd2));
        vecs.push_back(mk(1,0,32'h10010008,0,            0,0,0,0,            1,0,1,11'd2));
        vecs.push_back(mk(1,0,32'h1001000B,0,            0,0,0,0,            1,0,1,11'd2));
        vecs.push_back(mk(0,0,0,0,            1,0,32'h10010010,0,            0,1,1,11'd4));
        vecs.push_back(mk(0,0,0,0,            1,0,32'h10010014,0,            0,1,1,11'd5));
        vecs.push_back(mk(0,0,0,0,            1,0,32'h10010018,0,            0,1,1,11'd6));
        vecs.push_back(mk(0,0,0,0,            0,0,0,0,                       0,0,0,11'd0));
        vecs.push_back(mk(0,0,0,0,            1,1,32'h10010020,32'h12345678, 0,1,1,11'd8));
        vecs.push_back(mk(1,0,32'h10010020,0, 0,0,0,0,                       1,0,1,11'd8));
        vecs.push_back(mk(1,0,32'h10012000,0, 0,0,0,0,                       1,0,ob,11'd0));
        vecs.push_back(mk(0,0,0,0,            1,0,32'h00400000,0,            0,1,ob,11'd0));
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) vecs.push_back(mk(1,0,A4,0, 1,0,AC,0, 1,0,1,11'd1));
            vecs.push_back(mk(1,0,A4,0, 1,0,AC,0, 0,1,1,11'd3));
        end
        // req1 drops after two losses: its wait count must restart from zero.
        for (int j = 0; j < 2; j++) vecs.push_back(mk(1,0,A4,0, 1,0,AC,0, 1,0,1,11'd1));
        vecs.push_back(mk(1,1,A4,32'hA1B2C3D4, 0,0,0,0, 1,0,1,11'd1));
        for (int j = 0; j < 4; j++) vecs.push_back(mk(1,0,A4,0, 1,0,AC,0, 1,0,1,11'd1));
        vecs.push_back(mk(1,0,A4,0, 1,0,AC,0, 0,1,1,11'd3));

        req0 = 1; we0 = 1; addr0 = 32'h10010008; wdata0 = 32'h11111111;
        req1 = 1; we1 = 1; addr1 = 32'h10010010; wdata1 = 32'h22222222;
        exp_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {gnt0, gnt1, rvalid0, rvalid1, err, dm_ena, dm_we, 21'(dm_addr)}
            | rdata0 | rdata1 | dm_wdata, 32'h0);
        chk("reset no write", mem[2], ref_mem[2]);
        @(posedge clk); #1;
        rst_n = 1'b1;
        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Reset between a read grant and its rvalid cycle drops the response.
        req0 = 1; we0 = 0; addr0 = 32'h10010008; req1 = 0;
        @(negedge clk);
        chk("rst-mid-read gnt0", 32'(gnt0), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0; req0 = 0;
        #1 chk("rst-mid-read rvalid0", 32'(rvalid0), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst-mid-read idle rvalid0", 32'(rvalid0), 32'd0);

        // Reset asserted during a write grant: no DMEM write on that edge.
        req0 = 1; we0 = 1; addr0 = 32'h10010030; wdata0 = 32'hCAFEF00D;
        @(negedge clk); rst_n = 1'b0;
        #1 chk("rst-mid-write dm_we", 32'(dm_we), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req0 = 0;
        chk("rst-mid-write mem", mem[12], ref_mem[12]);
        exp_err = 1'b0;
        step(mk(1,0,32'h10010030,0, 0,0,0,0, 1,0,1,11'd12), "post-reset read");
        step(mk(0,0,0,0, 0,0,0,0, 0,0,0,11'd0), "drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
